cic3_sample_buffer: RTL and testbench
=====================================

Name: cic3_sample_buffer

Overview:
- Downstream neighbour of the 3rd-order CIC decimator.
- Runs on the fast modulator clock and keeps its own decimation phase counter.
- Once per decimation period it captures the CIC's unsigned NUMBITS-bit output and converts it to a saturated two's-complement sample. Settling samples after enable are discarded; valid samples go into a small first-word-fall-through FIFO read through a valid/ready handshake by the readout logic.

Parameters:
- DECIMATION_FACTOR, 256, decimation ratio D; must be a power of two ≥ 4; must match the CIC.
- CLOCK_WIDTH, $clog2(DECIMATION_FACTOR), phase counter width.
- NUMBITS, 3*CLOCK_WIDTH+1, CIC output width.
- OUT_WIDTH, NUMBITS-1, output sample width; 2 ≤ OUT_WIDTH ≤ NUMBITS-1.
- CAPTURE_PHASE, 2, phase counter value at which cic_in is sampled; range 0..D-1.
- SETTLE_SAMPLES, 4, number of captures discarded after enable rises; range 0..15.
- FIFO_DEPTH, 8, FIFO entries; power of two ≥ 2.

Ports:
- clk  input  1  high-speed modulator clock; all logic is posedge.
- reset_n  input  1  asynchronous digital reset (active low).
- enable  input  1  run/hold for the phase counter and capture.
- cic_in  input  NUMBITS  CIC filtered output, unsigned, range 0..2^(NUMBITS-1).
- fifo_flush  input  1  synchronous FIFO empty.
- clear_overflow  input  1  synchronous clear of the overflow flag.
- rd_ready  input  1  consumer accepts the head sample.
- rd_valid  output  1  FIFO not empty.
- rd_data  output  OUT_WIDTH  head sample, signed.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- settled  output  1  settle count reached; captures now reach the FIFO.
- overflow  output  1  sticky flag: a sample was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync deassert by the upstream reset generator):
  - phase=0, settle count=0, capture stage empty, FIFO empty.
  - rd_valid=0, rd_data=0, fifo_level=0, settled=0, overflow=0.
- Phase counter:
  - With enable=1, increments each clk and wraps from D-1 to 0.
  - With enable=0, held at 0.
- Capture:
  - Strobe = enable && phase==CAPTURE_PHASE, i.e. exactly one strobe per D cycles.
  - On the strobe edge, conv = cic_in − 2^(NUMBITS-2), computed in NUMBITS signed.
  - conv is saturated to [−2^(NUMBITS-2), 2^(NUMBITS-2)−1]. Only input 2^(NUMBITS-1) saturates, producing +max. Inputs above 2^(NUMBITS-1) also saturate to +max.
  - If OUT_WIDTH < NUMBITS-1, the result is arithmetic-shifted right by (NUMBITS-1−OUT_WIDTH), truncating toward −inf.
  - The result is registered in the capture stage together with a flag: keep = settled.
- Settling:
  - Each strobe with settle count < SETTLE_SAMPLES increments the count, and that capture is discarded.
  - settled = (count == SETTLE_SAMPLES). SETTLE_SAMPLES=0 gives settled=1 whenever out of reset.
  - enable falling clears the settle count and settled on the next edge. The FIFO contents are retained and stay readable.
- FIFO write:
  - A kept capture is written on the edge after the strobe edge.
  - Latency: a strobe at edge t into an empty FIFO gives rd_valid=1 and rd_data=sample after edge t+1.
- FIFO read:
  - rd_data shows the head entry, and shows 0 when empty.
  - A pop occurs on an edge where rd_valid && rd_ready; rd_ready with rd_valid=0 has no effect.
  - rd_data is stable while rd_valid=1 and rd_ready=0.
- Full:
  - A write while full with no pop in the same cycle drops the new sample (the oldest data is kept) and sets overflow.
  - A write and a pop in the same cycle while full: the write is accepted and the level is unchanged.
  - A write and a pop in the same cycle at level 1: the head advances to the new sample.
- fifo_flush: empties the FIFO on the next edge; a write in the same cycle is also discarded. overflow is unaffected.
- Overflow: clear_overflow clears it unless a drop occurs in the same cycle; set has priority.
- fifo_level is always equal to writes − pops, in the range 0..FIFO_DEPTH.
- Reset asserted mid-operation clears everything immediately, including a sample pending in the capture stage.

Test Plan:
- Reset, then enable=1, rd_ready=1, cic_in held at 2^23 (defaults) → first 4 strobes produce no rd_valid; settled rises after the 4th strobe; the 5th strobe (phase==2) yields rd_data=0x000000 one edge later.
- Saturation: cic_in=0 → rd_data=0x800000; cic_in=2^24 → rd_data=0x7FFFFF; cic_in=2^24−1 → 0x7FFFFF; cic_in=1 → 0x800001.
- Overflow: rd_ready=0 for 9 kept captures → fifo_level=8 and overflow=1; readout returns the first 8 samples in order; clear_overflow → overflow=0.
- Full plus simultaneous pop: level=8, rd_ready=1 on the write cycle → level stays 8, no overflow, the newest sample appears last.
- enable dropped for 100 cycles, then re-raised → phase restarts at 0, 4 samples discarded again, FIFO contents from before the drop still readable.
- reset_n pulsed low mid-period with 3 samples queued → outputs clear asynchronously; fifo_level=0, overflow=0, settled=0.

Source files
------------

// File: rtl/cic3_sample_buffer.sv
// rtl/cic3_sample_buffer.sv - CIC output capture, offset-binary to signed conversion and FWFT sample FIFO
module cic3_sample_buffer #(
    parameter int DECIMATION_FACTOR = 256,
    parameter int CLOCK_WIDTH       = $clog2(DECIMATION_FACTOR),
    parameter int NUMBITS           = 3 * CLOCK_WIDTH + 1,
    parameter int OUT_WIDTH         = NUMBITS - 1,
    parameter int CAPTURE_PHASE     = 2,
    parameter int SETTLE_SAMPLES    = 4,
    parameter int FIFO_DEPTH        = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic [NUMBITS-1:0]              cic_in,
    input  logic                            fifo_flush,
    input  logic                            clear_overflow,
    input  logic                            rd_ready,
    output logic                            rd_valid,
    output logic [OUT_WIDTH-1:0]            rd_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            settled,
    output logic                            overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CLOCK_WIDTH-1:0] CAP_PH   = CLOCK_WIDTH'(CAPTURE_PHASE);
    localparam logic [3:0]             SETTLE_N = 4'(SETTLE_SAMPLES);
    localparam logic [LW-1:0]          DEPTH_L  = LW'(FIFO_DEPTH);
    localparam logic [NUMBITS:0]       HALF     = (NUMBITS + 1)'(1) << (NUMBITS - 2);
    localparam logic [NUMBITS-2:0]     SAT_MAX  = {1'b0, {(NUMBITS - 2){1'b1}}};

    logic [CLOCK_WIDTH-1:0] phase_q, phase_d;
    logic [3:0]             settle_cnt_q, settle_cnt_d;
    logic                   cap_valid_q, cap_valid_d;
    logic [OUT_WIDTH-1:0]   cap_data_q, cap_data_d;
    logic [OUT_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [OUT_WIDTH-1:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   overflow_q, overflow_d;

    logic                   strobe;
    logic [NUMBITS:0]       ext;
    logic [NUMBITS-2:0]     sat;
    logic                   pop, push, drop, full;

    // One extra bit keeps inputs above full scale from wrapping negative before saturation.
    always_comb begin
        ext = {1'b0, cic_in} - HALF;
        sat = ext[NUMBITS-2:0];
        if (!ext[NUMBITS] && (ext[NUMBITS-1] || ext[NUMBITS-2])) begin
            sat = SAT_MAX;
        end
    end

    assign strobe  = enable && (phase_q == CAP_PH);
    assign settled = (settle_cnt_q == SETTLE_N);

    always_comb begin
        phase_d      = enable ? phase_q + 1'b1 : '0;
        settle_cnt_d = settle_cnt_q;
        if (!enable) begin
            settle_cnt_d = '0;
        end else if (strobe && !settled) begin
            settle_cnt_d = settle_cnt_q + 1'b1;
        end
        cap_valid_d = strobe && settled;
        cap_data_d  = strobe ? sat[NUMBITS-2 -: OUT_WIDTH] : cap_data_q;
    end

    assign full = (level_q == DEPTH_L);
    assign pop  = rd_valid && rd_ready;
    assign push = cap_valid_q && (!full || pop) && !fifo_flush;
    assign drop = cap_valid_q && full && !pop && !fifo_flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = cap_data_q;
        end
        if (fifo_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q      <= '0;
            settle_cnt_q <= '0;
            cap_valid_q  <= 1'b0;
            cap_data_q   <= '0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            settle_cnt_q <= settle_cnt_d;
            cap_valid_q  <= cap_valid_d;
            cap_data_q   <= cap_data_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
        end
    end

    assign rd_valid   = (level_q != '0);
    assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_cic3_sample_buffer.sv
// tb/tb_cic3_sample_buffer.sv - directed self-checking bench for cic3_sample_buffer
module tb_cic3_sample_buffer;

    localparam logic [24:0] HALF = 25'h0800000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [24:0] cic_in;
    logic        fifo_flush;
    logic        clear_overflow;
    logic        rd_ready;
    logic        rd_valid;
    logic [23:0] rd_data;
    logic [3:0]  fifo_level;
    logic        settled;
    logic        overflow;

    int checks   = 0;
    int failures = 0;
    int ph       = 0;

    cic3_sample_buffer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .cic_in         (cic_in),
        .fifo_flush     (fifo_flush),
        .clear_overflow (clear_overflow),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .fifo_level     (fifo_level),
        .settled        (settled),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One active edge; the bench tracks the expected decimation phase itself.
    task automatic tick();
        @(posedge clk);
        if (enable) ph = (ph + 1) % 256;
        else        ph = 0;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive cic_in and advance through the next capture edge.
    task automatic strobe(input logic [24:0] cin);
        bit hit;
        int guard;
        cic_in = cin;
        hit    = 1'b0;
        guard  = 0;
        while (!hit && guard < 300) begin
            hit = enable && (ph == 2);
            tick();
            guard++;
        end
        checks++;
        assert (hit) else begin
            failures++;
            $error("FAIL strobe_timeout observed=0 expected=1");
        end
    endtask

    logic [24:0] sat_in  [6] = '{25'h0000000, 25'h1000000, 25'h0FFFFFF, 25'h0000001, 25'h1FFFFFF, 25'h0800005};
    logic [23:0] sat_exp [6] = '{24'h800000, 24'h7FFFFF, 24'h7FFFFF, 24'h800001, 24'h7FFFFF, 24'h000005};

    initial begin
        reset_n = 1'b0; enable = 1'b0; cic_in = HALF;
        fifo_flush = 1'b0; clear_overflow = 1'b0; rd_ready = 1'b0;
        ticks(3);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_level", fifo_level, 0);
        chk("reset_settled", settled, 0);
        chk("reset_overflow", overflow, 0);
        @(negedge clk); reset_n = 1'b1;
        tick();

        enable = 1'b1; rd_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            strobe(HALF);
            chk($sformatf("settle_flag_%0d", k), settled, (k == 4));
            tick();
            chk($sformatf("settle_discard_%0d", k), rd_valid, 0);
        end
        strobe(HALF);
        chk("first_kept_not_yet", rd_valid, 0);
        tick();
        chk("first_kept_valid", rd_valid, 1);
        chk("first_kept_data", rd_data, 24'h000000);

        for (int i = 0; i < 6; i++) begin
            strobe(sat_in[i]);
            tick();
            chk($sformatf("sat_valid_%0d", i), rd_valid, 1);
            chk($sformatf("sat_data_%0d", i), rd_data, sat_exp[i]);
        end
        tick();
        chk("sat_drained", fifo_level, 0);

        rd_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            strobe(HALF + 25'(100 + i));
            tick();
            chk($sformatf("ovf_level_%0d", i), fifo_level, (i < 8) ? i + 1 : 8);
            chk($sformatf("ovf_flag_%0d", i), overflow, (i == 8));
            chk($sformatf("ovf_head_%0d", i), rd_data, 100);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_read_valid_%0d", i), rd_valid, 1);
            chk($sformatf("ovf_read_data_%0d", i), rd_data, 100 + i);
            tick();
        end
        chk("ovf_read_empty", rd_valid, 0);
        chk("ovf_read_empty_data", rd_data, 0);

        rd_ready = 1'b0;
        strobe(HALF + 25'd50); tick();
        strobe(HALF + 25'd51); tick();
        chk("flush_pre_level", fifo_level, 2);
        fifo_flush = 1'b1; tick(); fifo_flush = 1'b0;
        chk("flush_level", fifo_level, 0);
        chk("flush_valid", rd_valid, 0);
        chk("flush_keeps_overflow", overflow, 1);
        clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
        chk("overflow_cleared", overflow, 0);

        for (int i = 0; i < 8; i++) begin
            strobe(HALF + 25'(200 + i)); tick();
        end
        chk("fullpop_pre_level", fifo_level, 8);
        strobe(HALF + 25'd208);
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        chk("fullpop_level", fifo_level, 8);
        chk("fullpop_overflow", overflow, 0);
        chk("fullpop_head", rd_data, 201);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fullpop_read_%0d", i), rd_data, 201 + i);
            tick();
        end
        chk("fullpop_empty", fifo_level, 0);

        rd_ready = 1'b0;
        strobe(HALF + 25'd300); tick();
        strobe(HALF + 25'd301); tick();
        enable = 1'b0;
        tick();
        chk("disable_settled", settled, 0);
        ticks(100);
        chk("disable_level", fifo_level, 2);
        chk("disable_head", rd_data, 300);
        enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            strobe(HALF + 25'd999); tick();
            chk($sformatf("resettle_level_%0d", k), fifo_level, 2);
        end
        chk("resettle_settled", settled, 1);
        strobe(HALF + 25'd302);
        chk("resettle_write_pending", fifo_level, 2);
        tick();
        chk("resettle_write_done", fifo_level, 3);
        chk("resettle_head", rd_data, 300);

        strobe(HALF + 25'd303);
        reset_n = 1'b0;
        #2;
        chk("async_rst_valid", rd_valid, 0);
        chk("async_rst_data", rd_data, 0);
        chk("async_rst_level", fifo_level, 0);
        chk("async_rst_settled", settled, 0);
        chk("async_rst_overflow", overflow, 0);
        enable = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        ticks(2);
        chk("rst_pending_dropped", fifo_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
